// File: rtl/timer_pkg.sv
// rtl/timer_pkg.sv - shared state encoding and width helper for the interval timer
package timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSE  = 2'd2,
        ST_EXPIRE = 2'd3
    } timer_state_e;

    // ceil(log2(n)), never less than 1 so a counter always has at least one bit
    function automatic int clog2_min1(input int n);
        int r;
        r = 0;
        for (int v = n - 1; v > 0; v = v >> 1) begin
            r = r + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// rtl/tick_prescaler.sv - divides clk into one-cycle ticks every CLK_DIV enabled cycles
//   clk    : system clock
//   aclr   : asynchronous active-low reset
//   clr    : synchronous clear of the phase counter
//   enable : advance the phase counter this cycle
//   tick   : high on the enabled cycle where the counter wraps
module tick_prescaler
    import timer_pkg::*;
#(
    parameter int CLK_DIV = 50
) (
    input  logic clk,
    input  logic aclr,
    input  logic clr,
    input  logic enable,
    output logic tick
);

    localparam int PW = clog2_min1(CLK_DIV);
    localparam logic [PW-1:0] LAST = PW'(CLK_DIV - 1);

    logic [PW-1:0] r_cnt;
    logic          w_wrap;

    assign w_wrap = (r_cnt == LAST);

    always_ff @(posedge clk or negedge aclr) begin
        if (!aclr) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (enable) begin
            r_cnt <= w_wrap ? '0 : r_cnt + 1'b1;
        end
    end

    // Gated by enable so a held (paused) counter sitting on LAST never ticks
    assign tick = enable && w_wrap;

endmodule

// File: rtl/interval_timer_ctrl.sv
// rtl/interval_timer_ctrl.sv - one-shot / auto-reload interval timer with pause and abort
//   clk, aclr        : clock, asynchronous active-low reset
//   start            : begin timing from load_val (IDLE only)
//   pause            : level, freezes prescaler and count while high
//   abort            : return to IDLE, highest priority
//   periodic         : 0 one-shot, 1 auto-reload (sampled on start)
//   load_val [W]     : start count in ticks (sampled on start)
//   count [W]        : remaining ticks
//   busy/paused/done : status; done is a one-cycle pulse in EXPIRE
//   Macro INTERVAL_TIMER_IRQ_EN adds irq_clr (in) and irq (out), a sticky done flag.
module interval_timer_ctrl
    import timer_pkg::*;
#(
    parameter int CLK_DIV = 50,
    parameter int W       = 16
) (
    input  logic         clk,
    input  logic         aclr,
    input  logic         start,
    input  logic         pause,
    input  logic         abort,
    input  logic         periodic,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] count,
    output logic         busy,
    output logic         paused,
    output logic         done
`ifdef INTERVAL_TIMER_IRQ_EN
    ,
    input  logic         irq_clr,
    output logic         irq
`endif
);

    timer_state_e r_state, w_state_nxt;
    logic [W-1:0] r_count, w_count_nxt;
    logic [W-1:0] r_load;
    logic         r_mode;
    logic         w_take_start;
    logic         w_run;
    logic         w_psc_clr;
    logic         w_tick;

    assign w_take_start = (r_state == ST_IDLE) && start && !abort;

    // A paused timer whose pause has dropped counts on the same edge it
    // returns to RUN, so a pause costs exactly as many cycles as it was high.
    assign w_run     = ((r_state == ST_RUN) || (r_state == ST_PAUSE)) && !pause && !abort;
    assign w_psc_clr = abort || (r_state == ST_IDLE) || (r_state == ST_EXPIRE);

    tick_prescaler #(
        .CLK_DIV (CLK_DIV)
    ) u_prescaler (
        .clk     (clk),
        .aclr    (aclr),
        .clr     (w_psc_clr),
        .enable  (w_run),
        .tick    (w_tick)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        if (abort) begin
            w_state_nxt = ST_IDLE;
            w_count_nxt = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        w_count_nxt = load_val;
                        w_state_nxt = (load_val == '0) ? ST_EXPIRE : ST_RUN;
                    end
                end
                ST_RUN, ST_PAUSE: begin
                    if (pause) begin
                        w_state_nxt = ST_PAUSE;
                    end else begin
                        w_state_nxt = ST_RUN;
                        if (w_tick) begin
                            if (r_count > W'(1)) begin
                                w_count_nxt = r_count - W'(1);
                            end else begin
                                w_count_nxt = '0;
                                w_state_nxt = ST_EXPIRE;
                            end
                        end
                    end
                end
                ST_EXPIRE: begin
                    if (r_mode) begin
                        w_count_nxt = r_load;
                        w_state_nxt = ST_RUN;
                    end else begin
                        w_count_nxt = '0;
                        w_state_nxt = ST_IDLE;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_count_nxt = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge aclr) begin
        if (!aclr) begin
            r_state <= ST_IDLE;
            r_count <= '0;
            r_load  <= '0;
            r_mode  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
            if (w_take_start) begin
                r_load <= load_val;
                r_mode <= periodic;
            end
        end
    end

    assign count  = r_count;
    assign busy   = (r_state != ST_IDLE);
    assign paused = (r_state == ST_PAUSE);
    assign done   = (r_state == ST_EXPIRE);

`ifdef INTERVAL_TIMER_IRQ_EN
    logic r_irq;

    // done feeds both the set and the output, so irq rises with done and a
    // clear that lands during done is overridden
    always_ff @(posedge clk or negedge aclr) begin
        if (!aclr) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= done || (r_irq && !irq_clr);
        end
    end

    assign irq = r_irq || done;
`endif

endmodule

// File: tb/tb_interval_timer_ctrl.sv
// tb/tb_interval_timer_ctrl.sv - self-checking bench for interval_timer_ctrl
module tb_interval_timer_ctrl;

    localparam int D = 4;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         aclr;
    logic         start, pause, abort, periodic;
    logic [W-1:0] load_val;
    logic [W-1:0] count;
    logic         busy, paused, done;
`ifdef INTERVAL_TIMER_IRQ_EN
    logic         irq_clr, irq;
`else
    logic         irq_clr;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    interval_timer_ctrl #(.CLK_DIV(D), .W(W)) dut (
        .clk      (clk),
        .aclr     (aclr),
        .start    (start),
        .pause    (pause),
        .abort    (abort),
        .periodic (periodic),
        .load_val (load_val),
        .count    (count),
        .busy     (busy),
        .paused   (paused),
        .done     (done)
`ifdef INTERVAL_TIMER_IRQ_EN
        ,
        .irq_clr  (irq_clr),
        .irq      (irq)
`endif
    );

    // Reference model: remaining time kept in clk cycles, count derived by division
    int m_phase;   // 0 idle, 1 timing, 2 expired
    int m_rem;
    int m_load;
    bit m_per;
    bit m_paused;
    bit m_irq;

    function automatic void model_reset();
        m_phase = 0; m_rem = 0; m_load = 0; m_per = 0; m_paused = 0; m_irq = 0;
    endfunction

    function automatic void model_step();
        bit was_done;
        was_done = (m_phase == 2);
        m_irq = was_done || (m_irq && !irq_clr);
        if (abort) begin
            m_phase = 0; m_rem = 0; m_paused = 0;
        end else if (m_phase == 0) begin
            if (start) begin
                m_load = int'(load_val);
                m_per  = periodic;
                m_paused = 0;
                m_rem  = m_load * D;
                m_phase = (m_load == 0) ? 2 : 1;
            end
        end else if (m_phase == 1) begin
            if (pause) begin
                m_paused = 1;
            end else begin
                m_paused = 0;
                m_rem = m_rem - 1;
                if (m_rem == 0) m_phase = 2;
            end
        end else begin
            if (m_per) begin
                m_rem = m_load * D;
                m_phase = 1;
            end else begin
                m_phase = 0;
            end
        end
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s act=%0d exp=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        check("count",  int'(count),  (m_phase == 1) ? (m_rem + D - 1) / D : 0);
        check("busy",   int'(busy),   (m_phase != 0) ? 1 : 0);
        check("paused", int'(paused), (m_phase == 1 && m_paused) ? 1 : 0);
        check("done",   int'(done),   (m_phase == 2) ? 1 : 0);
`ifdef INTERVAL_TIMER_IRQ_EN
        check("irq",    int'(irq),    (m_irq || m_phase == 2) ? 1 : 0);
`endif
    endtask

    // One clock: model sees the same pre-edge inputs as the DUT, outputs compared at negedge
    task automatic step();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic clean_abort();
        start = 0; pause = 0; irq_clr = 0; abort = 1;
        step();
        abort = 0;
    endtask

    typedef struct {
        int load;
        bit per;
        int pause_at;
        int pause_len;
        int abort_at;
        int win;
        int exp_first;
        int exp_num;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int first, nd;

        vecs[0] = '{3, 1'b0, -1, 0, -1, 20, 12, 1};  // one-shot
        vecs[1] = '{2, 1'b1, -1, 0, -1, 26,  8, 3};  // periodic, dones at 8,17,26
        vecs[2] = '{2, 1'b0,  2, 10, -1, 25, 18, 1}; // pause delays by 10
        vecs[3] = '{3, 1'b0,  2, 10, -1, 28, 22, 1}; // pause delays by 10
        vecs[4] = '{5, 1'b0, -1, 0,  5, 25, -1, 0};  // abort, no done
        vecs[5] = '{0, 1'b0, -1, 0, -1,  4,  0, 1};  // zero load expires at once
        vecs[6] = '{2, 1'b0,  4, 3, -1, 16, 11, 1};  // pause on the tick edge
        vecs[7] = '{1, 1'b1, -1, 0, -1, 14,  4, 3};  // periodic load 1, dones 4,9,14

        aclr = 0; start = 0; pause = 0; abort = 0; periodic = 0;
        load_val = '0; irq_clr = 0;
        model_reset();
        repeat (3) @(negedge clk);
        compare_all();
        aclr = 1;

        foreach (vecs[i]) begin
            load_val = W'(vecs[i].load);
            periodic = vecs[i].per;
            start = 1;
            step();
            start = 0;
            first = done ? 0 : -1;
            nd = done ? 1 : 0;
            for (int k = 1; k <= vecs[i].win; k++) begin
                pause = (k >= vecs[i].pause_at) && (k < vecs[i].pause_at + vecs[i].pause_len);
                abort = (k == vecs[i].abort_at);
                step();
                if (done) begin
                    if (first < 0) first = k;
                    nd++;
                end
            end
            check($sformatf("vec%0d_first_done", i), first, vecs[i].exp_first);
            check($sformatf("vec%0d_num_done", i), nd, vecs[i].exp_num);
            clean_abort();
        end

        // start while busy is ignored, including new load/periodic
        load_val = 8'd3; periodic = 0; start = 1;
        step();
        first = -1;
        for (int k = 1; k <= 14; k++) begin
            start = (k == 2);
            if (k == 2) begin load_val = 8'd7; periodic = 1; end
            step();
            if (done && first < 0) first = k;
        end
        start = 0;
        check("busy_start_first_done", first, 12);
        check("busy_start_idle_after", int'(busy), 0);
        check("busy_start_count_after", int'(count), 0);

        // asynchronous reset mid-run
        load_val = 8'd5; periodic = 0; start = 1;
        step();
        start = 0;
        repeat (4) step();
        #2 aclr = 0;
        #1;
        check("aclr_async_busy", int'(busy), 0);
        check("aclr_async_count", int'(count), 0);
        check("aclr_async_done", int'(done), 0);
        model_reset();
        #1 aclr = 1;
        load_val = 8'd1; start = 1;
        step();
        start = 0;
        first = -1;
        for (int k = 1; k <= 6; k++) begin
            step();
            if (done && first < 0) first = k;
        end
        check("after_aclr_first_done", first, 4);

`ifdef INTERVAL_TIMER_IRQ_EN
        // irq: set with first done, held, clear coinciding with done loses, then clears
        clean_abort();
        load_val = 8'd1; periodic = 1; start = 1;
        step();
        start = 0;
        for (int k = 1; k <= 12; k++) begin
            irq_clr = (k == 10) || (k == 12);
            step();
            if (k == 4)  check("irq_rise", int'(irq), 1);
            if (k == 6)  check("irq_hold", int'(irq), 1);
            if (k == 10) check("irq_set_wins", int'(irq), 1);
            if (k == 12) check("irq_cleared", int'(irq), 0);
        end
        irq_clr = 0;
`endif
        clean_abort();

        // randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            start    = ($urandom % 4) == 0;
            pause    = ($urandom % 5) == 0;
            abort    = ($urandom % 40) == 0;
            irq_clr  = ($urandom % 6) == 0;
            load_val = W'($urandom_range(0, 4));
            periodic = (load_val != '0) && ($urandom % 2 == 1);
            step();
        end
        clean_abort();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
